// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
// Control unit for the multicycle MIPS datapath. It contains a Moore main FSM
// with registered control outputs, and a combinational ALU decoder.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (0 = in reset)
//   op         instruction[31:26] from the instruction register
//   funct      instruction[5:0] from the instruction register
//   zero       ALU zero flag
//   pcen       PC enable = pcwrite | (branch & zero)
//   memwrite   memory write strobe
//   irwrite    instruction register load
//   regwrite   register file write
//   iord       memory address select (0 = PC, 1 = ALUOut)
//   memtoreg   writeback select (1 = memory data)
//   regdst     destination select (1 = rd, 0 = rt)
//   alusrca    ALU A select (0 = PC, 1 = rs)
//   alusrcb    ALU B select (00 rt, 01 4, 10 signimm, 11 signimm<<2)
//   pcsrc      next-PC select (00 ALU result, 01 ALUOut, 10 jump target)
//   alucontrol ALU operation
//   state      current FSM state (debug)
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

    state_t cur;
    state_t nxt;
    ctrl_t  ctrl_q;

    // Control word for a given state; anything not set stays 0.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alusrcb = 2'b01;
                c.irwrite = 1'b1;
                c.pcwrite = 1'b1;
            end
            S_DECODE: begin
                c.alusrcb = 2'b11;
            end
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            S_MEMRD: begin
                c.iord = 1'b1;
            end
            S_MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            S_MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b10;
            end
            S_ALUWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            S_BEQEX: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b01;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            S_ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            S_ADDIWB: begin
                c.regwrite = 1'b1;
            end
            S_JEX: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state logic; unknown opcodes and illegal encodings return to FETCH.
    always_comb begin
        nxt = S_FETCH;
        case (cur)
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: begin
                if (op == OP_LW || op == OP_SW) nxt = S_MEMADR;
                else if (op == OP_RTYPE)        nxt = S_EXECUTE;
                else if (op == OP_BEQ)          nxt = S_BEQEX;
                else if (op == OP_ADDI)         nxt = S_ADDIEX;
                else if (op == OP_J)            nxt = S_JEX;
                else                            nxt = S_FETCH;
            end
            S_MEMADR: begin
                if (op == OP_LW)      nxt = S_MEMRD;
                else if (op == OP_SW) nxt = S_MEMWR;
                else                  nxt = S_FETCH;
            end
            S_MEMRD:   nxt = S_MEMWB;
            S_EXECUTE: nxt = S_ALUWB;
            S_ADDIEX:  nxt = S_ADDIWB;
            default:   nxt = S_FETCH;
        endcase
    end

    // The control word is registered alongside the state so that every
    // output is a clean flop of the state it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur    <= S_FETCH;
            ctrl_q <= decode(S_FETCH);
        end else begin
            cur    <= nxt;
            ctrl_q <= decode(nxt);
        end
    end

    // Write enables are gated by the live reset so they drop the instant
    // reset asserts, while the registered control word still holds the FETCH
    // values needed in the first cycle after release.
    assign pcen     = reset & (ctrl_q.pcwrite | (ctrl_q.branch & zero));
    assign memwrite = reset & ctrl_q.memwrite;
    assign irwrite  = reset & ctrl_q.irwrite;
    assign regwrite = reset & ctrl_q.regwrite;
    assign iord     = ctrl_q.iord;
    assign memtoreg = ctrl_q.memtoreg;
    assign regdst   = ctrl_q.regdst;
    assign alusrca  = ctrl_q.alusrca;
    assign alusrcb  = ctrl_q.alusrcb;
    assign pcsrc    = ctrl_q.pcsrc;
    assign state    = cur;

    // ALU decoder
    always_comb begin
        alucontrol = 3'b010;
        case (ctrl_q.aluop)
            2'b00: alucontrol = 3'b010;
            2'b01: alucontrol = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

endmodule
